ef9345_bus_master: RTL and testbench
====================================

Name: ef9345_bus_master

Overview:
Upstream stage of the ef9345 video-processor register file. Converts synchronous single-beat CPU I/O requests (VG5000 ports 8Fh = address, CFh = data) into the EF9345 multiplexed-bus protocol: AS, DS, RW, CS_ and the shared data bus.
- Address phase: drives the register index; ef9345 latches it on the AS falling edge.
- Data phase: ef9345 writes on the DS rising edge, or drives read data while RW is high.
- Sits between the Z80 I/O decoder and ef9345. The top level builds the tristate from bus_dout/bus_oe.

Parameters:
SETUP_CYC, 2, clk_in cycles bus value/mode lines are stable before a strobe asserts (1..15)
STROBE_CYC, 3, clk_in cycles a strobe stays asserted (1..15)
HOLD_CYC, 2, clk_in cycles bus value is held after a strobe deasserts (1..15)

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst_  in  1  asynchronous active-low reset
cpu_req  in  1  request, level; sampled only in IDLE
cpu_is_addr  in  1  1 = address cycle (port 8Fh), 0 = data cycle (port CFh)
cpu_we  in  1  1 = write, 0 = read (address cycles are always writes; cpu_we ignored)
cpu_wdata  in  8  address or write data
cpu_rdata  out  8  read data, valid while cpu_ack=1 after a read
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  high from request acceptance until the cycle after ack
bus_dout  out  8  value driven onto the data bus
bus_oe  out  1  tristate enable for bus_dout
bus_din  in  8  data bus as seen from ef9345
as  out  1  address strobe, active high; falling edge latches
ds  out  1  data strobe
rw  out  1  1 = read, 0 = write
cs_  out  1  chip select, active low

Behaviour:
- Reset (async, rst_=0): state IDLE, counter 0.
  - Outputs: as=0, ds=0, rw=1, cs_=1, bus_oe=0, bus_dout=0, cpu_ack=0, busy=0, cpu_rdata=0.
  - Reset mid-cycle aborts the transaction with no ack. ef9345 may already have latched an address; that is acceptable.
- States and transitions. Each timed state loads the counter with its parameter minus 1 and exits when the counter reaches 0.
  - IDLE: if cpu_req, capture cpu_wdata, cpu_is_addr and cpu_we; set busy=1; go to A_SETUP if address cycle, else D_SETUP.
  - A_SETUP (SETUP_CYC): cs_=0, ds=0, bus_oe=1, bus_dout=addr. Next A_STROBE.
  - A_STROBE (STROBE_CYC): as=1. Next A_HOLD.
  - A_HOLD (HOLD_CYC): as=0 with bus still driven, so the falling edge latches a stable value. Next DONE.
  - D_SETUP (SETUP_CYC): cs_=0, ds=0, rw=~we.
    - Write: bus_oe=1, bus_dout=data.
    - Read: bus_oe=0.
    - Next D_STROBE.
  - D_STROBE (STROBE_CYC): ds=1. Write data is captured on the DS rising edge. On read, ef9345 drives the bus from D_SETUP onward. Next D_HOLD.
  - D_HOLD (HOLD_CYC): ds=0, write data still driven. On the final hold cycle of a read, sample bus_din into cpu_rdata. Next DONE.
  - DONE (1 cycle): cs_=1, rw=1, bus_oe=0, cpu_ack=1. Next IDLE with busy=0.
- Latency from accept to ack:
  - Address cycle: SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (defaults: 8).
  - Data cycle: same count (defaults: 8).
- Back-to-back requests: cpu_req held high after ack starts the next cycle from IDLE one clock later. There is always at least one IDLE cycle with cs_=1.
- Requests during busy are ignored. The requester holds cpu_req until ack.
- cpu_rdata holds its last read value until the next read completes. Writes do not alter it.
- Mode: ds=0 at every AS falling edge (Motorola mode) unless the optional feature is enabled.

Optional Feature:
EF9345_INTEL_MODE_EN:
- Defined:
  - ds idles high and stays high through A_STROBE/A_HOLD, so ef9345 selects Intel mode.
  - Write data phase: rw pulses low in D_STROBE while ds stays high.
  - Read data phase: ds pulses low in D_STROBE while rw stays high.
  - rdata is sampled on the last D_HOLD cycle, with ds already back high.
  - Reset value of ds becomes 1.
- Undefined: Motorola behaviour as above.

Decomposition:
- ef9345_pkg:
  - State enum (IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE).
  - Port constants EF_PORT_ADDR=8'h8F and EF_PORT_DATA=8'hCF.
  - 4-bit timer width constant.
- Sub-module ef9345_phase_timer: loadable 4-bit down-counter with a zero flag. The FSM instantiates one.

Test Plan:
- Reset: assert rst_ mid-A_STROBE. Required: as=0, cs_=1, bus_oe=0 immediately (no clock edge); no ack.
- Address write 8'h25 at defaults:
  - as high for exactly 3 cycles, with bus_dout=8'h25 and ds=0 at its falling edge.
  - ack 8 cycles after accept.
  - Connected ef9345 latches index 5.
- Data write 8'hA5 after address 8'h23: ef9345 R3 = 8'hA5; rw=0 throughout D_SETUP..D_HOLD; ds high 3 cycles.
- Data read with R3=8'h5A: bus_oe=0 and rw=1 during the data phase; cpu_rdata=8'h5A with ack.
- Back-to-back: cpu_req held for address then data. Required: exactly one cs_=1 cycle between the two cycles; busy low only during that gap; second ack 9 cycles after the first.
- EF9345_INTEL_MODE_EN defined, write 8'h11 to R1: ds=1 at the AS fall; rw low pulse of 3 cycles; R1=8'h11.

Source files
------------

// File: rtl/ef9345_pkg.sv
// ef9345_pkg: shared FSM states, port constants and timer width for the ef9345 bus master
package ef9345_pkg;
  localparam int TMR_W = 4;
  localparam logic [7:0] EF_PORT_ADDR = 8'h8F;
  localparam logic [7:0] EF_PORT_DATA = 8'hCF;
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE} state_t;
endpackage

// File: rtl/ef9345_phase_timer.sv
// ef9345_phase_timer: loadable down-counter with zero flag timing each bus phase
module ef9345_phase_timer
  import ef9345_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk_in or negedge rst_)
    if (!rst_) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/ef9345_bus_master.sv
// ef9345_bus_master: CPU single-beat I/O to ef9345 multiplexed bus (AS/DS/RW/CS_)
// Define EF9345_INTEL_MODE_EN for Intel-mode strobes (ds idles high, rw/ds pulse low).
module ef9345_bus_master
  import ef9345_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 2
) (
  input  logic       clk_in,
  input  logic       rst_,
  input  logic       cpu_req,
  input  logic       cpu_is_addr,
  input  logic       cpu_we,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       busy,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din,
  output logic       as,
  output logic       ds,
  output logic       rw,
  output logic       cs_
);
  state_t state, next;
  logic             we_q, zero, load, a_phase, d_phase;
  logic [7:0]       data_q;
  logic [TMR_W-1:0] load_val;
  ef9345_phase_timer u_tmr (.clk_in(clk_in), .rst_(rst_), .load(load), .load_val(load_val), .zero(zero));
  always_ff @(posedge clk_in or negedge rst_)
    if (!rst_) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk_in or negedge rst_)
    if (!rst_) begin
      we_q   <= 1'b0;
      data_q <= '0;
    end else if (state == IDLE && cpu_req) begin
      we_q   <= cpu_we;
      data_q <= cpu_wdata;
    end
  // read data is taken on the last hold cycle, while ef9345 is still driving
  always_ff @(posedge clk_in or negedge rst_)
    if (!rst_) cpu_rdata <= '0;
    else if (state == D_HOLD && zero && !we_q) cpu_rdata <= bus_din;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = cpu_req ? (cpu_is_addr ? A_SETUP : D_SETUP) : IDLE;
      A_SETUP:  next = zero ? A_STROBE : A_SETUP;
      A_STROBE: next = zero ? A_HOLD : A_STROBE;
      A_HOLD:   next = zero ? DONE : A_HOLD;
      D_SETUP:  next = zero ? D_STROBE : D_SETUP;
      D_STROBE: next = zero ? D_HOLD : D_STROBE;
      D_HOLD:   next = zero ? DONE : D_HOLD;
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    load     = next != state;
    load_val = (next == A_SETUP  || next == D_SETUP)  ? TMR_W'(SETUP_CYC - 1) :
               (next == A_STROBE || next == D_STROBE) ? TMR_W'(STROBE_CYC - 1) :
               (next == A_HOLD   || next == D_HOLD)   ? TMR_W'(HOLD_CYC - 1) : '0;
  end
  always_comb begin
    a_phase  = state == A_SETUP || state == A_STROBE || state == A_HOLD;
    d_phase  = state == D_SETUP || state == D_STROBE || state == D_HOLD;
    cs_      = !(a_phase || d_phase);
    bus_oe   = a_phase || (d_phase && we_q);
    bus_dout = bus_oe ? data_q : '0;
    as       = state == A_STROBE;
    cpu_ack  = state == DONE;
    busy     = state != IDLE;
`ifdef EF9345_INTEL_MODE_EN
    ds       = !(state == D_STROBE && !we_q);
    rw       = !(state == D_STROBE && we_q);
`else
    ds       = state == D_STROBE;
    rw       = !(d_phase && we_q);
`endif
  end
endmodule

// File: tb/tb_ef9345_bus_master.sv
// tb_ef9345_bus_master: randomized directed bench with an ef9345 register-file model
module tb_ef9345_bus_master;
  localparam int S = 2, T = 3, H = 2, LAT = S + T + H + 1;
`ifdef EF9345_INTEL_MODE_EN
  localparam bit INTEL = 1'b1;
`else
  localparam bit INTEL = 1'b0;
`endif
  logic       clk_in = 1'b0, rst_ = 1'b0;
  logic       cpu_req = 1'b0, cpu_is_addr = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_wdata = '0, cpu_rdata, bus_dout, bus_din;
  logic       cpu_ack, busy, bus_oe, as, ds, rw, cs_;
  int vectors = 0, miscompares = 0;
  int lat, as_hi, ds_act, rw_lo, oe_cnt;
  logic       fall_ds;
  logic [7:0] fall_dout;
  logic [7:0] ref_regs [8];
  logic [2:0] ref_idx;
  logic [7:0] ref_rd = '0;
  logic [7:0] sregs [8];
  logic [2:0] sidx;

  always #5 clk_in = ~clk_in;

  ef9345_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk_in(clk_in), .rst_(rst_), .cpu_req(cpu_req), .cpu_is_addr(cpu_is_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din), .as(as), .ds(ds), .rw(rw), .cs_(cs_));

  // ef9345 slave: index latched on AS fall, data on DS rise (Motorola) or RW rise (Intel)
  always @(negedge as) if (!cs_ && bus_oe) sidx <= bus_dout[2:0];
`ifdef EF9345_INTEL_MODE_EN
  always @(posedge rw) if (!cs_ && ds && bus_oe) sregs[sidx] <= bus_dout;
`else
  always @(posedge ds) if (!cs_ && !rw && bus_oe) sregs[sidx] <= bus_dout;
`endif
  assign bus_din = (!cs_ && !bus_oe) ? sregs[sidx] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic a, input logic w, input logic [7:0] d);
    logic pa;
    @(negedge clk_in);
    cpu_req = 1'b1; cpu_is_addr = a; cpu_we = w; cpu_wdata = d;
    lat = 0; as_hi = 0; ds_act = 0; rw_lo = 0; oe_cnt = 0;
    fall_ds = 1'bx; fall_dout = 'x; pa = 1'b0;
    do begin
      @(negedge clk_in);
      lat++;
      as_hi += int'(as); ds_act += int'(ds != INTEL); rw_lo += int'(!rw); oe_cnt += int'(bus_oe);
      if (pa && !as) begin fall_ds = ds; fall_dout = bus_dout; end
      pa = as;
    end while (!cpu_ack && lat < 40);
    cpu_req = 1'b0;
  endtask

  task automatic run(input logic a, input logic w, input logic [7:0] d);
    txn(a, w, d);
    chk("latency", lat, LAT);
    chk("as_cycles", as_hi, a ? T : 0);
    chk("oe_cycles", oe_cnt, (a || w) ? S + T + H : 0);
    chk("ds_active", ds_act, (!a && (!INTEL || !w)) ? T : 0);
    chk("rw_low", rw_lo, (!a && w) ? (INTEL ? T : S + T + H) : 0);
    if (a) begin
      ref_idx = d[2:0];
      chk("as_fall_dout", fall_dout, d);
      chk("as_fall_ds", fall_ds, INTEL);
      chk("slave_index", sidx, ref_idx);
    end else if (w) begin
      ref_regs[ref_idx] = d;
      chk("slave_reg", sregs[ref_idx], d);
      chk("rdata_kept", cpu_rdata, ref_rd);
    end else begin
      ref_rd = ref_regs[ref_idx];
      chk("rdata", cpu_rdata, ref_rd);
    end
  endtask

  initial begin
    int n, gap_cs, gap_busy, acks;
    repeat (3) @(negedge clk_in);
    chk("rst_as", as, 0); chk("rst_ds", ds, INTEL); chk("rst_rw", rw, 1); chk("rst_cs", cs_, 1);
    chk("rst_oe", bus_oe, 0); chk("rst_dout", bus_dout, 0); chk("rst_ack", cpu_ack, 0);
    chk("rst_busy", busy, 0); chk("rst_rdata", cpu_rdata, 0);
    rst_ = 1'b1;
    run(1'b1, 1'b0, 8'h25);
    run(1'b1, 1'b0, 8'h23);
    run(1'b0, 1'b1, 8'hA5);
    run(1'b0, 1'b1, 8'h5A);
    run(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      run(1'b1, 1'b0, 8'(($urandom & 32'hF8) | i));
      run(1'b0, 1'b1, 8'($urandom));
    end
    // back-to-back: request held across the first ack
    @(negedge clk_in);
    cpu_req = 1'b1; cpu_is_addr = 1'b1; cpu_we = 1'b0; cpu_wdata = 8'h21;
    n = 0;
    while (!cpu_ack && n < 40) begin @(negedge clk_in); n++; end
    chk("b2b_first_ack", n, LAT);
    cpu_is_addr = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h77;
    n = 0; gap_cs = 0; gap_busy = 0;
    do begin
      @(negedge clk_in);
      n++; gap_cs += int'(cs_ && !cpu_ack); gap_busy += int'(!busy);
    end while (!cpu_ack && n < 40);
    cpu_req = 1'b0;
    chk("b2b_ack_gap", n, LAT + 1);
    chk("b2b_cs_idle", gap_cs, 1);
    chk("b2b_busy_low", gap_busy, 1);
    chk("b2b_slave_reg", sregs[1], 8'h77);
    ref_idx = 3'd1; ref_regs[1] = 8'h77;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run(k == 0, k == 1, 8'($urandom));
    end
    // asynchronous reset in the middle of the address strobe
    @(negedge clk_in);
    cpu_req = 1'b1; cpu_is_addr = 1'b1; cpu_wdata = 8'h26;
    n = 0;
    while (!as && n < 20) begin @(negedge clk_in); n++; end
    chk("reach_strobe", as, 1);
    @(posedge clk_in); #2;
    rst_ = 1'b0; #1;
    chk("arst_as", as, 0); chk("arst_cs", cs_, 1); chk("arst_oe", bus_oe, 0);
    chk("arst_ack", cpu_ack, 0); chk("arst_busy", busy, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_ = 1'b1;
    acks = 0;
    repeat (12) begin @(negedge clk_in); acks += int'(cpu_ack); end
    chk("arst_no_ack", acks, 0);
    chk("arst_rdata", cpu_rdata, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
